// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse transmitter.
//   RAM_WIDTH_DEF : default width of count fields and internal counters
//   state_t       : burst state encoding (idle / active phase / inactive phase)
package pulse_pkg;

  localparam int RAM_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_INACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_gen.sv
// Programmable pulse/PWM burst transmitter.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | line at io_defaultLevel, waiting for io_start
// ACTIVE   | line at ~latched level for max(high,1) clocks
// INACTIVE | line at latched level for max(low,1) clocks, then count pulse
//
// Ports:
//   io_clk          : clock, rising edge
//   io_rst          : asynchronous active-high reset
//   io_start        : start a burst (acted on only in IDLE)
//   io_stop         : abort a burst; wins over io_start in IDLE
//   io_highCnt      : active phase length in clocks (0 treated as 1)
//   io_lowCnt       : inactive phase length in clocks (0 treated as 1)
//   io_pulseNum     : pulses per burst, 0 = continuous until stopped
//   io_defaultLevel : idle/inactive line level
//   io_pulse_out    : registered pulse line
//   io_busy         : burst in progress
//   io_done         : one-cycle strobe on normal burst completion
module pulse_gen
  import pulse_pkg::*;
#(
  parameter int _RAM_WIDTH = RAM_WIDTH_DEF
) (
  input  logic                  io_clk,
  input  logic                  io_rst,
  input  logic                  io_start,
  input  logic                  io_stop,
  input  logic [_RAM_WIDTH-1:0] io_highCnt,
  input  logic [_RAM_WIDTH-1:0] io_lowCnt,
  input  logic [_RAM_WIDTH-1:0] io_pulseNum,
  input  logic                  io_defaultLevel,
  output logic                  io_pulse_out,
  output logic                  io_busy,
  output logic                  io_done
);

  typedef logic [_RAM_WIDTH-1:0] cnt_t;

  state_t state_q, state_d;
  cnt_t   phase_cnt_q, phase_cnt_d;
  cnt_t   pulse_cnt_q, pulse_cnt_d;
  cnt_t   high_q, high_d;
  cnt_t   low_q, low_d;
  cnt_t   num_q, num_d;
  logic   level_q, level_d;
  logic   pulse_out_q, pulse_out_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  // Phase reload value: max(len,1)-1, so a zero length still lasts one clock.
  function automatic cnt_t len_m1(input cnt_t len);
    return (len == '0) ? '0 : len - cnt_t'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    high_d      = high_q;
    low_d       = low_q;
    num_d       = num_q;
    level_d     = level_q;
    pulse_out_d = pulse_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pulse_out_d = io_defaultLevel;
        busy_d      = 1'b0;
        if (io_start && !io_stop) begin
          high_d      = io_highCnt;
          low_d       = io_lowCnt;
          num_d       = io_pulseNum;
          level_d     = io_defaultLevel;
          phase_cnt_d = len_m1(io_highCnt);
          pulse_cnt_d = '0;
          pulse_out_d = ~io_defaultLevel;
          busy_d      = 1'b1;
          state_d     = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (io_stop) begin
          pulse_out_d = level_q;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else if (phase_cnt_q == '0) begin
          phase_cnt_d = len_m1(low_q);
          pulse_out_d = level_q;
          state_d     = ST_INACTIVE;
        end else begin
          phase_cnt_d = phase_cnt_q - cnt_t'(1);
        end
      end

      ST_INACTIVE: begin
        if (io_stop) begin
          pulse_out_d = level_q;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else if (phase_cnt_q == '0) begin
          // In continuous mode the pulse counter simply wraps.
          pulse_cnt_d = pulse_cnt_q + cnt_t'(1);
          if ((num_q != '0) && (pulse_cnt_d == num_q)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            phase_cnt_d = len_m1(high_q);
            pulse_out_d = ~level_q;
            state_d     = ST_ACTIVE;
          end
        end else begin
          phase_cnt_d = phase_cnt_q - cnt_t'(1);
        end
      end

      default: begin
        pulse_out_d = io_defaultLevel;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      state_q     <= ST_IDLE;
      phase_cnt_q <= '0;
      pulse_cnt_q <= '0;
      high_q      <= '0;
      low_q       <= '0;
      num_q       <= '0;
      level_q     <= 1'b0;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      high_q      <= high_d;
      low_q       <= low_d;
      num_q       <= num_d;
      level_q     <= level_d;
      pulse_out_q <= pulse_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign io_pulse_out = pulse_out_q;
  assign io_busy      = busy_q;
  assign io_done      = done_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed self-checking bench for pulse_gen.
module tb_pulse_gen;

  logic        io_clk = 1'b0;
  logic        io_rst = 1'b1;
  logic        io_start = 1'b0;
  logic        io_stop = 1'b0;
  logic [31:0] io_highCnt = '0;
  logic [31:0] io_lowCnt = '0;
  logic [31:0] io_pulseNum = '0;
  logic        io_defaultLevel = 1'b0;
  logic        io_pulse_out;
  logic        io_busy;
  logic        io_done;

  int n_checks = 0;
  int n_errors = 0;

  pulse_gen dut (
    .io_clk          (io_clk),
    .io_rst          (io_rst),
    .io_start        (io_start),
    .io_stop         (io_stop),
    .io_highCnt      (io_highCnt),
    .io_lowCnt       (io_lowCnt),
    .io_pulseNum     (io_pulseNum),
    .io_defaultLevel (io_defaultLevel),
    .io_pulse_out    (io_pulse_out),
    .io_busy         (io_busy),
    .io_done         (io_done)
  );

  always #5 io_clk = ~io_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge io_clk);
    #1;
  endtask

  // Start a finite burst and compare every cycle against the hand model.
  // Observation j reflects the edge j-1 after the start edge E (spec cycle E+j).
  // Ends in the done cycle so a following call starts back-to-back.
  task automatic check_burst(input string tag, input int h, input int l, input int n,
                             input logic lvl, input bit disturb);
    int   he, le, per, last, pos;
    logic eo, eb, ed;
    io_highCnt      = h;
    io_lowCnt       = l;
    io_pulseNum     = n;
    io_defaultLevel = lvl;
    io_start        = 1'b1;
    step();
    io_start = 1'b0;
    he   = (h == 0) ? 1 : h;
    le   = (l == 0) ? 1 : l;
    per  = he + le;
    last = n * per + 1;
    for (int j = 1; j <= last; j++) begin
      if (j < last) begin
        pos = (j - 1) % per;
        eo  = (pos < he) ? ~lvl : lvl;
        eb  = 1'b1;
        ed  = 1'b0;
      end else begin
        eo = lvl;
        eb = 1'b0;
        ed = 1'b1;
      end
      check($sformatf("%s out c%0d", tag, j), io_pulse_out, eo);
      check($sformatf("%s busy c%0d", tag, j), io_busy, eb);
      check($sformatf("%s done c%0d", tag, j), io_done, ed);
      if (disturb && j == 4) begin
        io_start        = 1'b1;
        io_highCnt      = 7;
        io_lowCnt       = 1;
        io_pulseNum     = 1;
        io_defaultLevel = ~lvl;
      end
      if (disturb && j == 6) begin
        io_start        = 1'b0;
        io_defaultLevel = lvl;
      end
      if (j < last) step();
    end
  endtask

  // Run a burst and count active runs at least filt clocks long.
  task automatic loopback(input int h, input int l, input int n, input int filt,
                          input int exp_caught);
    int run, caught;
    bit done_seen;
    run       = 0;
    caught    = 0;
    done_seen = 0;
    io_highCnt      = h;
    io_lowCnt       = l;
    io_pulseNum     = n;
    io_defaultLevel = 1'b0;
    io_start        = 1'b1;
    step();
    io_start = 1'b0;
    for (int c = 0; c < 1000 && !done_seen; c++) begin
      if (io_pulse_out) run++;
      else begin
        if (run >= filt) caught++;
        run = 0;
      end
      if (io_done) done_seen = 1;
      if (!done_seen) step();
    end
    check($sformatf("loop h%0d done", h), 32'(done_seen), 32'd1);
    check($sformatf("loop h%0d caught", h), caught, exp_caught);
    step();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst out", io_pulse_out, 0);
    check("rst busy", io_busy, 0);
    check("rst done", io_done, 0);
    io_defaultLevel = 1'b1;
    step();
    step();
    io_rst = 1'b0;
    check("post-rst out held", io_pulse_out, 0);
    step();
    check("post-rst out follows", io_pulse_out, 1);
    io_defaultLevel = 1'b0;
    step();
    check("idle out low", io_pulse_out, 0);

    // Basic burst with mid-burst start/config disturbance, then a
    // back-to-back zero/inverted burst started in the done cycle.
    check_burst("basic", 3, 2, 4, 1'b0, 1'b1);
    check_burst("zero", 0, 0, 2, 1'b1, 1'b0);
    step();
    check("after zero out", io_pulse_out, 1);
    check("after zero done", io_done, 0);
    check("after zero busy", io_busy, 0);

    // Continuous mode aborted during the 3rd pulse
    io_defaultLevel = 1'b0;
    io_highCnt      = 5;
    io_lowCnt       = 5;
    io_pulseNum     = 0;
    io_start        = 1'b1;
    step();
    io_start = 1'b0;
    for (int j = 1; j <= 22; j++) begin
      logic eo;
      eo = (((j - 1) % 10) < 5) ? 1'b1 : 1'b0;
      check($sformatf("cont out c%0d", j), io_pulse_out, eo);
      check($sformatf("cont busy c%0d", j), io_busy, 1);
      if (j < 22) step();
    end
    io_stop = 1'b1;
    step();
    io_stop = 1'b0;
    check("stop out", io_pulse_out, 0);
    check("stop busy", io_busy, 0);
    check("stop done", io_done, 0);
    for (int j = 0; j < 4; j++) begin
      step();
      check("stop idle done", io_done, 0);
      check("stop idle busy", io_busy, 0);
    end

    // start and stop together in IDLE
    io_defaultLevel = 1'b1;
    io_highCnt      = 3;
    io_pulseNum     = 1;
    io_start        = 1'b1;
    io_stop         = 1'b1;
    step();
    check("s+s busy", io_busy, 0);
    check("s+s out", io_pulse_out, 1);
    step();
    check("s+s busy2", io_busy, 0);
    io_start = 1'b0;
    io_stop  = 1'b0;
    io_defaultLevel = 1'b0;
    step();

    // Reset during ACTIVE
    io_highCnt  = 20;
    io_lowCnt   = 5;
    io_pulseNum = 1;
    io_start    = 1'b1;
    step();
    io_start = 1'b0;
    step();
    step();
    step();
    check("pre-rst busy", io_busy, 1);
    check("pre-rst out", io_pulse_out, 1);
    io_rst = 1'b1;
    #1;
    check("mid-rst out", io_pulse_out, 0);
    check("mid-rst busy", io_busy, 0);
    check("mid-rst done", io_done, 0);
    io_defaultLevel = 1'b1;
    step();
    io_rst = 1'b0;
    check("rel out held", io_pulse_out, 0);
    step();
    check("rel out follows", io_pulse_out, 1);
    check("rel busy", io_busy, 0);
    io_defaultLevel = 1'b0;
    step();

    // Loopback with a 10-clock pulse filter model
    loopback(50, 50, 3, 10, 3);
    loopback(5, 5, 3, 10, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
# pulse_gen

Programmable pulse/PWM transmitter that drives a feedback-style line with bursts of pulses of configurable active width, inactive width, count and idle level. It is the transmit side of the `PulseCatch` filtered pulse receiver: its output is what `PulseCatch` samples on `io_fb_in`. It is used both as a stimulus source in loopback benches and as the on-chip pulse driver.

## Interface
Parameters:
- `_RAM_WIDTH`, default 32: width of all count fields and internal counters.

Ports:
- `io_clk` — in, 1: single clock; all logic is rising-edge.
- `io_rst` — in, 1: asynchronous, active-high reset.
- `io_start` — in, 1: start a burst. Level-sampled; acted on only in IDLE.
- `io_stop` — in, 1: abort the current burst. Level-sampled.
- `io_highCnt` — in, `_RAM_WIDTH`: active-phase length in clocks. 0 is treated as 1.
- `io_lowCnt` — in, `_RAM_WIDTH`: inactive-phase length in clocks. 0 is treated as 1.
- `io_pulseNum` — in, `_RAM_WIDTH`: number of pulses in the burst. 0 means continuous until stopped.
- `io_defaultLevel` — in, 1: idle/inactive line level. The active level is `~io_defaultLevel`.
- `io_pulse_out` — out, 1: registered pulse line.
- `io_busy` — out, 1: high while a burst is in progress.
- `io_done` — out, 1: one-cycle strobe on normal burst completion.

## Operation
- States: IDLE, ACTIVE, INACTIVE.
- IDLE:
  - `io_pulse_out` <= `io_defaultLevel`, updated every clock.
  - `io_busy` = 0.
  - If `io_start` = 1 and `io_stop` = 0: latch `io_highCnt`, `io_lowCnt`, `io_pulseNum` and `io_defaultLevel`, then go to ACTIVE.
- ACTIVE:
  - `io_pulse_out` = ~latched level.
  - The phase counter is loaded with max(high,1)-1 and counts down.
  - At 0, go to INACTIVE.
- INACTIVE:
  - `io_pulse_out` = latched level.
  - The phase counter is loaded with max(low,1)-1.
  - At 0, increment the pulse counter. If the pulse counter equals the latched pulseNum (pulseNum ≠ 0), go to IDLE and assert `io_done`. Otherwise go to ACTIVE.
- Input changes during a burst have no effect; only the latched copies are used.
- `io_start` while busy is ignored; there is no queuing.
- `io_stop` = 1 in ACTIVE or INACTIVE:
  - Next state is IDLE.
  - `io_pulse_out` returns to the latched idle level on the next edge.
  - No `io_done`.
- `io_start` and `io_stop` asserted together in IDLE: stop wins and the block stays IDLE.
- Continuous mode (pulseNum = 0): the pulse counter wraps freely; `io_done` is never asserted.
- Counter arithmetic is unsigned `_RAM_WIDTH` bits. Max count 2^W-1 is legal; there is no overflow in the phase counter.
- Reset, mid-burst or not, immediately forces IDLE with all counters cleared.

## Timing
- Reset values: `io_pulse_out` = 0, `io_busy` = 0, `io_done` = 0, state IDLE, counters 0.
- After reset release, `io_pulse_out` follows `io_defaultLevel` with 1-clock latency.
- `io_start` sampled at edge E:
  - `io_pulse_out` is active and `io_busy` = 1 from edge E+1.
  - The active level holds for exactly max(high,1) clocks, then the inactive level for exactly max(low,1) clocks.
  - Period is max(high,1) + max(low,1) clocks, with no gap cycles between pulses.
- Burst of N pulses started at E: `io_done` = 1 and `io_busy` = 0 in the same cycle, starting at edge E+1+N·period. `io_done` lasts 1 clock.
- A new `io_start` is accepted in the cycle `io_done` is high, with no dead cycle.
- `io_stop` sampled at edge S: from S+1, `io_pulse_out` = idle level and `io_busy` = 0.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `pulse_pkg`:
  - state typedef (IDLE/ACTIVE/INACTIVE, 2-bit encoding);
  - default `_RAM_WIDTH` constant.
- Single module. Phase and pulse counters are inline; no sub-module is needed.

## Test plan
- Reset mid-burst: assert `io_rst` during ACTIVE with high=20 -> `io_pulse_out`, `io_busy`, `io_done` = 0 immediately; after release, output equals `io_defaultLevel` 1 clock later.
- Basic burst: defaultLevel=0, high=3, low=2, pulseNum=4, start at E -> output high in E+1..E+3, low in E+4..E+5, repeated 4 times; `io_done` exactly at E+21; `io_busy` high E+1..E+20.
- Zero/inverted config: defaultLevel=1, high=0, low=0, pulseNum=2 -> output 0,1,0,1 for one clock each; done at E+5.
- Abort and priority:
  - pulseNum=0, high=5, low=5; stop asserted in the 3rd pulse -> output returns to idle the next clock, no `io_done`.
  - start+stop together in IDLE -> no activity.
- Ignore/back-to-back:
  - start re-asserted while busy, and config changed mid-burst -> waveform unchanged.
  - start asserted during the `io_done` cycle -> new burst begins on the next clock.
- Loopback into `PulseCatch` (filterCnt=10, defaultLevel=0):
  - high=50, low=50, pulseNum=3 -> 3 pulses caught;
  - high=5 -> 0 pulses caught (filtered).
